mips_ctrl_alu: RTL and testbench
================================

Name: mips_ctrl_alu

Overview:
- Combined main control decoder, ALU-control decoder and 32-bit ALU for the MIPS-subset pipeline.
- Decodes opcode/funct into datapath control signals combinationally.
- Executes the selected ALU operation on the supplied operands and registers the result and zero flag on the rising clock edge.
- Sits between the ID register-file read and the EX/MEM pipeline register.

Parameters:
- DATA_WIDTH, 32, operand/result width; the sign bit is bit DATA_WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- a  in  DATA_WIDTH  operand A (rs value)
- b  in  DATA_WIDTH  operand B (rt value)
- imm  in  DATA_WIDTH  sign-extended immediate
- reg_dst  out  1  1 = destination is rd, 0 = rt
- branch  out  1  beq
- branch_n  out  1  bne
- mem_read  out  1  load
- mem_write  out  1  store
- mem_to_reg  out  1  writeback from memory
- jump  out  1  j
- alu_src  out  1  1 = ALU B input is imm
- reg_write  out  1  register-file write enable
- no_op  out  1  instruction is a bubble/unknown
- alu_op  out  2  main-to-ALU-control code
- alu_ctrl  out  3  ALU operation select
- alu_result  out  DATA_WIDTH  registered ALU result
- zero  out  1  registered (alu_result == 0)

Behaviour:
- Decode (combinational) by opcode. Signals not listed are 0.
  - 000000 R-type: reg_dst, reg_write; alu_op 10.
  - 100011 lw: alu_src, mem_read, mem_to_reg, reg_write; alu_op 00.
  - 101011 sw: alu_src, mem_write; alu_op 00.
  - 000100 beq: branch; alu_op 01.
  - 000101 bne: branch_n; alu_op 01.
  - 000010 j: jump; alu_op 00.
  - 001000 addi: alu_src, reg_write; alu_op 00.
  - 001010 slti: alu_src, reg_write; alu_op 11.
  - Any other opcode: all control signals 0, no_op = 1.
- While rst = 0, all decode outputs are forced to 0 and no_op is forced to 1, independent of opcode.
- ALU control (combinational), driven from alu_op and funct:
  - alu_op 00 → 010 ADD; 01 → 110 SUB; 11 → 111 SLT.
  - alu_op 10 decodes funct: 100000 → 010, 100010 → 110, 100100 → 000 AND, 100101 → 001 OR, 101010 → 111 SLT.
  - alu_op 10 with any other funct → 010 ADD.
- ALU:
  - B input = alu_src ? imm : b.
  - 000 AND, 001 OR, 010 a+B, 110 a−B: two's-complement, wrap modulo 2^DATA_WIDTH, no overflow flag.
  - 111 SLT: signed compare, result 1 if a<B else 0, zero-extended.
  - Unused codes (011, 100, 101) produce 0.
- Register stage:
  - On posedge clk with rst = 1: alu_result <= ALU output; zero <= (ALU output == 0).
  - Latency is 1 cycle from operand/opcode change to alu_result.
- Reset:
  - rst falling asynchronously clears alu_result to 0 and sets zero to 1, without waiting for a clock edge.
  - Both hold while rst = 0.
  - The first capture occurs on the first posedge after rst returns to 1.
  - Reset asserted mid-operation discards the pending result.
- No handshake; a new operation is accepted every cycle.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI.
  - funct constants.
  - ALU_AND/OR/ADD/SUB/SLT 3-bit constants.
  - ALUOP_ADD/SUB/FUNCT/SLT 2-bit constants.
- One sub-module is natural: `mips_alu_core`, holding the combinational ALU, with alu_ctrl, A, B in and result out.
- Main decode and ALU-control decode stay inline in mips_ctrl_alu.

Test Plan:
- Reset: hold rst = 0 with opcode 000000 → alu_result 0, zero 1, reg_write 0, no_op 1. Release rst → the next posedge captures the result.
- R-type, opcode 0:
  - funct 100000, a = 7, b = 5 → alu_ctrl 010, reg_dst 1, reg_write 1; after 1 clk alu_result 12, zero 0.
  - funct 100010 with a = b = 9 → alu_result 0, zero 1.
- R-type logic/compare:
  - funct 100100, a = 0xF0F0_00FF, b = 0x0FF0_0F0F → AND result 0x00F0_000F.
  - funct 101010, a = 0xFFFF_FFFF (−1), b = 1 → SLT result 1.
- lw/sw: opcode 100011, a = 0x100, imm = 0xFFFF_FFFC → alu_src 1, mem_read 1, mem_to_reg 1, alu_result 0xFC. Opcode 101011 → mem_write 1, reg_write 0.
- Branch/jump/unknown:
  - beq (000100) → branch 1, alu_ctrl 110.
  - bne (000101) → branch_n 1.
  - j (000010) → jump 1, reg_write 0.
  - opcode 111111 → all controls 0, no_op 1.
- Wrap and async reset: ADD a = 0x7FFF_FFFF, b = 1 → alu_result 0x8000_0000. Then drop rst between clock edges → alu_result 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS-subset control/ALU slice.
//   - opcode and funct field values
//   - 2-bit main-to-ALU-control codes (alu_op)
//   - 3-bit ALU operation selects (alu_ctrl)
//   - packed bundle of main-decode control outputs
package mips_pkg;

    // Opcode field values (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // Funct field values (instruction[5:0]) for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation selects
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Main-to-ALU-control codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // Main-decode control outputs as one bundle
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       branch_n;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic       alu_src;
        logic       reg_write;
        logic       no_op;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = 12'b0000_0000_0000;

endpackage

// File: rtl/mips_alu_core.sv
// mips_alu_core: purely combinational ALU.
// Ports:
//   alu_ctrl  in  3           operation select (AND/OR/ADD/SUB/SLT)
//   a         in  DATA_WIDTH  operand A
//   b         in  DATA_WIDTH  operand B (already muxed with the immediate)
//   result    out DATA_WIDTH  operation result; unused selects give 0
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    logic lt_s;

    // Signed less-than drives the SLT result
    assign lt_s = ($signed(a) < $signed(b));

    // Operation select; add/sub wrap naturally at DATA_WIDTH bits
    always_comb begin
        result = {DATA_WIDTH{1'b0}};
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            default: result = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/mips_ctrl_alu.sv
// mips_ctrl_alu: main control decoder, ALU-control decoder and registered
// 32-bit ALU for the MIPS-subset pipeline (between ID read and EX/MEM).
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   opcode, funct     instruction[31:26], instruction[5:0]
//   a, b, imm         rs value, rt value, sign-extended immediate
//   reg_dst..no_op    combinational datapath controls
//   alu_op, alu_ctrl  combinational ALU-control codes
//   alu_result, zero  ALU output and (output == 0), registered
module mips_ctrl_alu
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  reg_dst,
    output logic                  branch,
    output logic                  branch_n,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  jump,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  no_op,
    output logic [1:0]            alu_op,
    output logic [2:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero
);

    ctrl_t                 ctrl_s;
    logic [2:0]            alu_ctrl_s;
    logic [DATA_WIDTH-1:0] alu_b_s;
    logic [DATA_WIDTH-1:0] alu_out_s;
    logic [DATA_WIDTH-1:0] alu_result_r;
    logic                  zero_r;

    // Main decode; reset forces a bubble regardless of opcode
    always_comb begin
        ctrl_s = CTRL_ZERO;
        if (!rst) begin
            ctrl_s.no_op = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl_s.reg_dst   = 1'b1;
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_op    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    ctrl_s.alu_src    = 1'b1;
                    ctrl_s.mem_read   = 1'b1;
                    ctrl_s.mem_to_reg = 1'b1;
                    ctrl_s.reg_write  = 1'b1;
                    ctrl_s.alu_op     = ALUOP_ADD;
                end
                OP_SW: begin
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.mem_write = 1'b1;
                    ctrl_s.alu_op    = ALUOP_ADD;
                end
                OP_BEQ: begin
                    ctrl_s.branch = 1'b1;
                    ctrl_s.alu_op = ALUOP_SUB;
                end
                OP_BNE: begin
                    ctrl_s.branch_n = 1'b1;
                    ctrl_s.alu_op   = ALUOP_SUB;
                end
                OP_J: begin
                    ctrl_s.jump   = 1'b1;
                    ctrl_s.alu_op = ALUOP_ADD;
                end
                OP_ADDI: begin
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_op    = ALUOP_ADD;
                end
                OP_SLTI: begin
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_op    = ALUOP_SLT;
                end
                default: begin
                    ctrl_s.no_op = 1'b1;
                end
            endcase
        end
    end

    // ALU-control decode; unrecognised R-type functs fall back to ADD
    always_comb begin
        alu_ctrl_s = ALU_ADD;
        case (ctrl_s.alu_op)
            ALUOP_ADD: alu_ctrl_s = ALU_ADD;
            ALUOP_SUB: alu_ctrl_s = ALU_SUB;
            ALUOP_SLT: alu_ctrl_s = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl_s = ALU_ADD;
                    FN_SUB:  alu_ctrl_s = ALU_SUB;
                    FN_AND:  alu_ctrl_s = ALU_AND;
                    FN_OR:   alu_ctrl_s = ALU_OR;
                    FN_SLT:  alu_ctrl_s = ALU_SLT;
                    default: alu_ctrl_s = ALU_ADD;
                endcase
            end
            default: alu_ctrl_s = ALU_ADD;
        endcase
    end

    assign alu_b_s = ctrl_s.alu_src ? imm : b;

    mips_alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .alu_ctrl (alu_ctrl_s),
        .a        (a),
        .b        (alu_b_s),
        .result   (alu_out_s)
    );

    // Result/zero register; reset clears immediately and drops any pending result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_r <= {DATA_WIDTH{1'b0}};
            zero_r       <= 1'b1;
        end else begin
            alu_result_r <= alu_out_s;
            zero_r       <= (alu_out_s == {DATA_WIDTH{1'b0}});
        end
    end

    assign reg_dst    = ctrl_s.reg_dst;
    assign branch     = ctrl_s.branch;
    assign branch_n   = ctrl_s.branch_n;
    assign mem_read   = ctrl_s.mem_read;
    assign mem_write  = ctrl_s.mem_write;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign jump       = ctrl_s.jump;
    assign alu_src    = ctrl_s.alu_src;
    assign reg_write  = ctrl_s.reg_write;
    assign no_op      = ctrl_s.no_op;
    assign alu_op     = ctrl_s.alu_op;
    assign alu_ctrl   = alu_ctrl_s;
    assign alu_result = alu_result_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// tb_mips_ctrl_alu: directed self-checking bench for mips_ctrl_alu.
// Expected results are queued when an operation is driven and popped once
// the registered result is available one clock later.
module tb_mips_ctrl_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg;
    logic        jump, alu_src, reg_write, no_op;
    logic [1:0]  alu_op;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    mips_ctrl_alu #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .imm        (imm),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .branch_n   (branch_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .jump       (jump),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .no_op      (no_op),
        .alu_op     (alu_op),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ctl vector order: reg_dst,branch,branch_n,mem_read,mem_write,mem_to_reg,jump,alu_src,reg_write,no_op
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] iv,
                        input logic [9:0] ectl, input logic [1:0] eop, input logic [2:0] ealu,
                        input logic [31:0] eres);
        logic [31:0] e;
        @(negedge clk);
        opcode = op; funct = fn; a = av; b = bv; imm = iv;
        sb_q.push_back(eres);
        #1;
        chk({tag, ".ctl"}, {22'd0, reg_dst, branch, branch_n, mem_read, mem_write,
                            mem_to_reg, jump, alu_src, reg_write, no_op}, {22'd0, ectl});
        chk({tag, ".alu_op"}, {30'd0, alu_op}, {30'd0, eop});
        chk({tag, ".alu_ctrl"}, {29'd0, alu_ctrl}, {29'd0, ealu});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".result"}, alu_result, e);
            chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (e == 32'd0)});
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b000000; funct = 6'b000000;
        a = 32'd0; b = 32'd0; imm = 32'd0;

        // Reset held low: bubble decode, cleared result
        #2 rst = 1'b0;
        #1;
        chk("rst.result", alu_result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst.no_op", {31'd0, no_op}, 32'd1);
        chk("rst.reg_dst", {31'd0, reg_dst}, 32'd0);
        a = 32'd7; b = 32'd5; funct = 6'b100000;
        @(posedge clk); #1;
        chk("rst.hold", alu_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        step("add",   6'b000000, 6'b100000, 32'd7, 32'd5, 32'd0,
             10'b1000000010, 2'b10, 3'b010, 32'd12);
        step("sub",   6'b000000, 6'b100010, 32'd9, 32'd9, 32'd0,
             10'b1000000010, 2'b10, 3'b110, 32'd0);
        step("and",   6'b000000, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,
             10'b1000000010, 2'b10, 3'b000, 32'h00F0_000F);
        step("slt",   6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0,
             10'b1000000010, 2'b10, 3'b111, 32'd1);
        step("slt_n", 6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0,
             10'b1000000010, 2'b10, 3'b111, 32'd0);
        step("or",    6'b000000, 6'b100101, 32'h0000_00A0, 32'h0000_0005, 32'd0,
             10'b1000000010, 2'b10, 3'b001, 32'h0000_00A5);
        step("fn_def",6'b000000, 6'b000000, 32'd3, 32'd4, 32'd0,
             10'b1000000010, 2'b10, 3'b010, 32'd7);
        step("lw",    6'b100011, 6'b000000, 32'h100, 32'hDEAD, 32'hFFFF_FFFC,
             10'b0001010110, 2'b00, 3'b010, 32'hFC);
        step("sw",    6'b101011, 6'b000000, 32'h100, 32'hDEAD, 32'd8,
             10'b0000100100, 2'b00, 3'b010, 32'h108);
        step("beq",   6'b000100, 6'b100100, 32'd5, 32'd5, 32'd0,
             10'b0100000000, 2'b01, 3'b110, 32'd0);
        step("bne",   6'b000101, 6'b000000, 32'd5, 32'd3, 32'd0,
             10'b0010000000, 2'b01, 3'b110, 32'd2);
        step("j",     6'b000010, 6'b000000, 32'd1, 32'd2, 32'd100,
             10'b0000001000, 2'b00, 3'b010, 32'd3);
        step("addi",  6'b001000, 6'b000000, 32'd10, 32'd50, 32'hFFFF_FFFF,
             10'b0000000110, 2'b00, 3'b010, 32'd9);
        step("slti",  6'b001010, 6'b000000, 32'hFFFF_FFFE, 32'd50, 32'd0,
             10'b0000000110, 2'b11, 3'b111, 32'd1);
        step("unk",   6'b111111, 6'b100010, 32'd1, 32'd1, 32'd7,
             10'b0000000001, 2'b00, 3'b010, 32'd2);
        step("wrap",  6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'd0,
             10'b1000000010, 2'b10, 3'b010, 32'h8000_0000);

        // Reset dropped between edges with an operation pending
        @(negedge clk);
        opcode = 6'b000000; funct = 6'b100000; a = 32'd100; b = 32'd1;
        #2 rst = 1'b0;
        #1;
        chk("arst.result", alu_result, 32'd0);
        chk("arst.zero", {31'd0, zero}, 32'd1);
        chk("arst.no_op", {31'd0, no_op}, 32'd1);
        chk("arst.reg_write", {31'd0, reg_write}, 32'd0);
        @(posedge clk); #1;
        chk("arst.hold", alu_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First capture after release
        step("post",  6'b000000, 6'b100000, 32'd100, 32'd1, 32'd0,
             10'b1000000010, 2'b10, 3'b010, 32'd101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
